// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing (640x480@60 by default). Provides beam counters, delayed sync/blank and gated 24-bit RGB.
// Latency: counters move on the clk edge that ends a pixelTick. sync/blank/RGB lag them by SYNC_DELAY pixel ticks (SYNC_DELAY=0: one clk).
// Backpressure: none; the raster runs freely. Optional macro VGA_TEST_PATTERN_EN adds testMode colour bars.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic        clk,
  input  logic        botonRST,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        testMode,
`endif
  input  logic [23:0] rgbIn,
  output logic [9:0]  counterX,
  output logic [9:0]  counterY,
  output logic        pixelTick,
  output logic        frameStart,
  output logic        hsync,
  output logic        vsync,
  output logic        videoOn,
  output logic [23:0] RGB
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  // At least one stage always exists; with SYNC_DELAY=0 it reloads every clk.
  localparam int NST = (SYNC_DELAY > 0) ? SYNC_DELAY : 1;

  // Pipeline word layout: bit0 = visible, bit1 = vsync, bit2 = hsync, [5:3] = bar index.
`ifdef VGA_TEST_PATTERN_EN
  localparam int PW    = 6;
  localparam int BAR_W = H_VIS / 8;
`else
  localparam int PW    = 3;
`endif
  localparam logic [PW-1:0] PIPE_RST = PW'(3'b110);

  logic [1:0]    div_q, div_d;
  logic          tick_q, tick_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [PW-1:0] raw;
  logic [PW-1:0] pipe_q [NST];
  logic [PW-1:0] pipe_d [NST];
  logic [PW-1:0] out_next;
  logic [23:0]   rgb_q, rgb_d;

`ifdef VGA_TEST_PATTERN_EN
  // Bar palette, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction
`endif

  // Pixel divider: tick is registered one clk after the divider reaches its last count,
  // so the first tick after reset lands CLK_DIV clks after release.
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? 2'd0 : div_q + 2'd1;
    tick_d = (div_q == DIV_LAST);
  end

  // Beam counters; any out-of-range value wraps to 0 on the next tick.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick_q) begin
      if (x_q >= H_LAST) begin
        x_d = 10'd0;
        y_d = (y_q >= V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
        if (y_q > V_LAST) begin
          y_d = 10'd0;
        end
      end
    end
  end

  // Undelayed decode of the current beam position.
  always_comb begin
    raw    = '0;
    raw[0] = (x_q < H_VIS_W) && (y_q < V_VIS_W);
    raw[1] = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
    raw[2] = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
`ifdef VGA_TEST_PATTERN_EN
    raw[5:3] = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_q >= 10'(i * BAR_W)) begin
        raw[5:3] = 3'(i);
      end
    end
`endif
  end

  // Delay line: shifts on pixel ticks, or tracks the decode every clk when no delay is wanted.
  always_comb begin
    for (int i = 0; i < NST; i++) begin
      pipe_d[i] = pipe_q[i];
    end
    if ((SYNC_DELAY == 0) || tick_q) begin
      pipe_d[0] = raw;
    end
    if (tick_q) begin
      for (int i = 1; i < NST; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
    out_next = pipe_d[NST-1];
  end

  // RGB follows the value videoOn takes at the same edge, so colour never leaks into blanking.
  always_comb begin
    rgb_d = 24'h000000;
`ifdef VGA_TEST_PATTERN_EN
    if (out_next[0]) begin
      rgb_d = testMode ? bar_colour(out_next[5:3]) : rgbIn;
    end
`else
    if (out_next[0]) begin
      rgb_d = rgbIn;
    end
`endif
  end

  // Divider and counter state.
  always_ff @(posedge clk or negedge botonRST) begin
    if (!botonRST) begin
      div_q  <= 2'd0;
      tick_q <= 1'b0;
      x_q    <= 10'd0;
      y_q    <= 10'd0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  // Delay line and output colour state; reset leaves syncs inactive and video blanked.
  always_ff @(posedge clk or negedge botonRST) begin
    if (!botonRST) begin
      for (int i = 0; i < NST; i++) begin
        pipe_q[i] <= PIPE_RST;
      end
      rgb_q <= 24'h000000;
    end else begin
      for (int i = 0; i < NST; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      rgb_q <= rgb_d;
    end
  end

  assign counterX   = x_q;
  assign counterY   = y_q;
  assign pixelTick  = tick_q;
  assign frameStart = tick_q && (x_q == H_LAST) && (y_q == V_LAST);
  assign videoOn    = pipe_q[NST-1][0];
  assign vsync      = pipe_q[NST-1][1];
  assign hsync      = pipe_q[NST-1][2];
  assign RGB        = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: directed self-checking bench for vga_timing_gen (default horizontal timing, shortened frame of 12 lines).
// Latency: inputs driven and outputs sampled 1 ns after each rising clk edge.
// Backpressure: none; every wait on the DUT is bounded and a timeout counts as a failure.
module tb_vga_timing_gen;

  logic        clk;
  logic        botonRST;
  logic [23:0] rgbIn;
  logic [9:0]  counterX;
  logic [9:0]  counterY;
  logic        pixelTick;
  logic        frameStart;
  logic        hsync;
  logic        vsync;
  logic        videoOn;
  logic [23:0] RGB;
`ifdef VGA_TEST_PATTERN_EN
  logic        testMode;
`endif

  int n_checks;
  int n_fail;

  // Shortened frame: 6 visible lines, vsync on lines 8..9, 12 lines total.
  vga_timing_gen #(
    .V_VIS (6),
    .V_FP  (2),
    .V_SYNC(2),
    .V_BP  (2)
  ) dut (
    .clk       (clk),
    .botonRST  (botonRST),
`ifdef VGA_TEST_PATTERN_EN
    .testMode  (testMode),
`endif
    .rgbIn     (rgbIn),
    .counterX  (counterX),
    .counterY  (counterY),
    .pixelTick (pixelTick),
    .frameStart(frameStart),
    .hsync     (hsync),
    .vsync     (vsync),
    .videoOn   (videoOn),
    .RGB       (RGB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xy(input int wx, input int wy, input string tag);
    int n;
    n = 0;
    while (!(counterX == 10'(wx) && counterY == 10'(wy)) && n < 40000) begin
      step();
      n++;
    end
    chk(tag, 32'(n < 40000), 32'd1);
  endtask

  initial begin
    int n;
    int hs_low, vis_clks, rgb_white, rgb_bad, hs_first_x, vis_fall_x;
    int clk_cnt, vs_low, blank_rgb, vs_x, vs_y;
    bit prev_vis, vs_seen;

    n_checks = 0;
    n_fail   = 0;
    botonRST = 1'b0;
    rgbIn    = 24'hFFFFFF;
`ifdef VGA_TEST_PATTERN_EN
    testMode = 1'b0;
`endif

    // Reset state with a white input held: nothing may reach the outputs.
    repeat (4) step();
    chk("rst_x", 32'(counterX), 32'd0);
    chk("rst_y", 32'(counterY), 32'd0);
    chk("rst_tick", 32'(pixelTick), 32'd0);
    chk("rst_fs", 32'(frameStart), 32'd0);
    chk("rst_hs", 32'(hsync), 32'd1);
    chk("rst_vs", 32'(vsync), 32'd1);
    chk("rst_vid", 32'(videoOn), 32'd0);
    chk("rst_rgb", 32'(RGB), 32'd0);

    // Release: tick appears after the 2nd edge, counterX moves on the 3rd.
    botonRST = 1'b1;
    step();
    chk("rel_tick_e1", 32'(pixelTick), 32'd0);
    step();
    chk("rel_tick_e2", 32'(pixelTick), 32'd1);
    chk("rel_x_e2", 32'(counterX), 32'd0);
    step();
    chk("rel_x_e3", 32'(counterX), 32'd1);
    chk("rel_tick_e3", 32'(pixelTick), 32'd0);

    // counterX = k after edge 2k+1: 799 after edge 1599, wrap after edge 1601.
    repeat (1596) step();
    chk("x799", 32'(counterX), 32'd799);
    chk("x799_y", 32'(counterY), 32'd0);
    step();
    step();
    chk("wrap_x", 32'(counterX), 32'd0);
    chk("wrap_y", 32'(counterY), 32'd1);

    // One full line (line 1), 1600 clks.
    hs_low = 0; vis_clks = 0; rgb_white = 0; rgb_bad = 0;
    hs_first_x = -1; vis_fall_x = -1; prev_vis = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      if (!hsync) begin
        hs_low++;
        if (hs_first_x < 0) hs_first_x = int'(counterX);
      end
      if (videoOn) vis_clks++;
      if (prev_vis && !videoOn && vis_fall_x < 0) vis_fall_x = int'(counterX);
      prev_vis = videoOn;
      if (RGB == 24'hFFFFFF) rgb_white++;
      if (RGB != (videoOn ? 24'hFFFFFF : 24'h000000)) rgb_bad++;
      step();
    end
    chk("line_hs_low_clks", 32'(hs_low), 32'd192);
    chk("line_hs_first_x", 32'(hs_first_x), 32'd658);
    chk("line_vis_clks", 32'(vis_clks), 32'd1280);
    chk("line_vis_fall_x", 32'(vis_fall_x), 32'd642);
    chk("line_rgb_white", 32'(rgb_white), 32'd1280);
    chk("line_rgb_gating", 32'(rgb_bad), 32'd0);

    // Frame: 12 lines x 800 ticks x 2 clks between frameStart pulses.
    n = 0;
    while (!frameStart && n < 40000) begin
      step();
      n++;
    end
    chk("fs_found", 32'(n < 40000), 32'd1);
    chk("fs_x", 32'(counterX), 32'd799);
    chk("fs_y", 32'(counterY), 32'd11);
    chk("fs_tick", 32'(pixelTick), 32'd1);
    clk_cnt = 0; vs_low = 0; vis_clks = 0; rgb_bad = 0; blank_rgb = 0;
    vs_seen = 1'b0; vs_x = -1; vs_y = -1;
    do begin
      step();
      clk_cnt++;
      if (!vsync) begin
        vs_low++;
        if (!vs_seen) begin
          vs_seen = 1'b1;
          vs_x = int'(counterX);
          vs_y = int'(counterY);
        end
      end
      if (videoOn) vis_clks++;
      if (RGB != (videoOn ? 24'hFFFFFF : 24'h000000)) rgb_bad++;
      if (counterY >= 10'd6 && RGB != 24'h000000) blank_rgb++;
    end while (!frameStart && clk_cnt < 40000);
    chk("frame_clks", 32'(clk_cnt), 32'd19200);
    chk("frame_vs_low_clks", 32'(vs_low), 32'd3200);
    chk("frame_vs_first_x", 32'(vs_x), 32'd2);
    chk("frame_vs_first_y", 32'(vs_y), 32'd8);
    chk("frame_vis_clks", 32'(vis_clks), 32'd7680);
    chk("frame_rgb_gating", 32'(rgb_bad), 32'd0);
    chk("frame_blank_lines_rgb", 32'(blank_rgb), 32'd0);

    // RGB is re-registered every clk from rgbIn inside the visible area.
    wait_xy(300, 4, "wait_300_4");
    rgbIn = 24'hA5C3E1;
    step();
    chk("mid_vid", 32'(videoOn), 32'd1);
    chk("mid_rgb_follow", 32'(RGB), 32'hA5C3E1);

    // Asynchronous reset mid-frame: outputs clear without a clk edge.
    #2;
    botonRST = 1'b0;
    #1;
    chk("arst_x", 32'(counterX), 32'd0);
    chk("arst_y", 32'(counterY), 32'd0);
    chk("arst_vid", 32'(videoOn), 32'd0);
    chk("arst_rgb", 32'(RGB), 32'd0);
    chk("arst_hs", 32'(hsync), 32'd1);
    chk("arst_vs", 32'(vsync), 32'd1);
    rgbIn = 24'hFFFFFF;
    repeat (3) step();
    chk("arst_hold_rgb", 32'(RGB), 32'd0);
    botonRST = 1'b1;
    step();
    step();
    chk("restart_tick", 32'(pixelTick), 32'd1);
    step();
    chk("restart_x", 32'(counterX), 32'd1);
    chk("restart_y", 32'(counterY), 32'd0);

`ifdef VGA_TEST_PATTERN_EN
    // Bars: delayed column c shows when counterX = c+2; bar index = c/80; rgbIn ignored.
    testMode = 1'b1;
    rgbIn    = 24'h123456;
    wait_xy(2, 1, "wait_col0");
    chk("bar_col0", 32'(RGB), 32'hFFFFFF);
    wait_xy(82, 1, "wait_col80");
    chk("bar_col80", 32'(RGB), 32'hFFFF00);
    wait_xy(482, 1, "wait_col480");
    chk("bar_col480", 32'(RGB), 32'h0000FF);
    wait_xy(562, 1, "wait_col560");
    chk("bar_col560", 32'(RGB), 32'h000000);
    wait_xy(641, 1, "wait_col639");
    chk("bar_col639", 32'(RGB), 32'h000000);
    chk("bar_col639_vid", 32'(videoOn), 32'd1);
    testMode = 1'b0;
    step();
    chk("bar_off_rgb", 32'(RGB), 32'h123456);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
